// File: rtl/riscv_mem_pkg.sv
// Shared types for the data-memory responder: word geometry, the response
// tuple carried through the latency pipe and response FIFO, and the
// alignment check used on every request.
package riscv_mem_pkg;

    localparam int WORD_BYTES = 4;

    // One response as seen by the core: load data, store echo and error flag.
    typedef struct packed {
        logic [31:0] rdata;
        logic        write;
        logic        error;
    } rsp_t;

    localparam int RSP_W = $bits(rsp_t);

    // A request is misaligned when its byte offset within the word is nonzero.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/riscv_dmem_rsp_fifo.sv
// Synchronous response FIFO. Pointers carry one extra MSB so full and empty
// are told apart without a separate count; DEPTH must be a power of two >= 2
// for the modulo wrap to fall out of the pointer width. Storage is not reset,
// only the pointers are.
module riscv_dmem_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 34
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int IW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [IW:0]      wr_ptr;
    logic [IW:0]      rd_ptr;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    assign head_data = store[rd_ptr[IW-1:0]];

    // Advance write/read pointers on push/pop; cleared by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (IW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (IW+1)'(1);
            end
        end
    end

    // Write the pushed tuple into the slot addressed by the write pointer.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            store[wr_ptr[IW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder for the core's load/store port. Requests are served
// against a local word array on the accept edge; the response tuple then
// travels a fixed LATENCY-deep pipe into a response FIFO.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. The
// rsp_* payload stays stable while rsp_valid is high and rsp_ready is low.
//
// Flow control is by credit: out_cnt counts everything accepted but not yet
// popped (pipe plus FIFO). req_ready is registered from the next count, so
// the FIFO can never overflow and the pipe never has to stall.
module riscv_dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_WIDTH  = 12,
    parameter int LATENCY     = 2,
    parameter int RSP_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_write,
    output logic                  rsp_error
);

    localparam int            OFF_W    = $clog2(WORD_BYTES);
    localparam int            CW       = $clog2(RSP_DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RSP_DEPTH);

    logic [31:0]                 mem [DEPTH_WORDS];
    logic                        accept;
    logic                        pop;
    logic                        misaligned;
    logic [ADDR_WIDTH-OFF_W-1:0] word_idx;
    rsp_t                        new_rsp;
    logic [LATENCY-1:0]          pipe_vld;
    rsp_t                        pipe_dat [LATENCY];
    logic [CW-1:0]               out_cnt;
    logic [CW-1:0]               out_cnt_next;
    rsp_t                        head_rsp;
    logic                        fifo_full;
    logic                        fifo_empty;

    assign accept     = req_valid && req_ready;
    assign pop        = rsp_valid && rsp_ready;
    assign misaligned = is_misaligned(req_addr[1:0]);
    assign word_idx   = req_addr[ADDR_WIDTH-1:OFF_W];

    // Build the response tuple for the request presented this cycle.
    always_comb begin
        new_rsp       = '0;
        new_rsp.write = req_write;
        new_rsp.error = misaligned;
        if (!req_write && !misaligned) begin
            new_rsp.rdata = mem[word_idx];
        end
    end

    // Commit aligned stores byte by byte; the array itself is never reset.
    always_ff @(posedge clock) begin
        if (accept && req_write && !misaligned) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (req_be[b]) begin
                    mem[word_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Shift the valid bits of the latency pipe; reset discards in-flight work.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    // Shift the payload of the latency pipe alongside the valid bits.
    always_ff @(posedge clock) begin
        pipe_dat[0] <= new_rsp;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_dat[i] <= pipe_dat[i-1];
        end
    end

    // Next outstanding count: accept adds one, pop removes one, both cancel.
    always_comb begin
        out_cnt_next = out_cnt;
        if (accept && !pop) begin
            out_cnt_next = out_cnt + CW'(1);
        end else if (pop && !accept) begin
            out_cnt_next = out_cnt - CW'(1);
        end
    end

    // Register the credit count and the ready derived from it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_cnt   <= '0;
            req_ready <= 1'b0;
        end else begin
            out_cnt   <= out_cnt_next;
            req_ready <= (out_cnt_next < CNT_FULL);
        end
    end

    riscv_dmem_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (RSP_W)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (pipe_vld[LATENCY-1] && !fifo_full),
        .push_data (pipe_dat[LATENCY-1]),
        .pop       (pop),
        .head_data (head_rsp),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_rdata = fifo_empty ? 32'h0 : head_rsp.rdata;
    assign rsp_write = fifo_empty ? 1'b0  : head_rsp.write;
    assign rsp_error = fifo_empty ? 1'b0  : head_rsp.error;

endmodule
